// File: rtl/seq_wide_comparator_if.sv
// Handshake and operand bus for the multi-cycle wide comparator.
// The master drives the request and operands; the slave (the comparator)
// returns the status and result flags.
interface seq_wide_comparator_if #(
    parameter int WIDTH = 64
);
    logic             start_i;
    logic             mode_signed_i;
    logic [WIDTH-1:0] op1_i;
    logic [WIDTH-1:0] op2_i;
    logic             busy_o;
    logic             done_o;
    logic             zero_o;
    logic             sign_o;

    modport master (
        output start_i,
        output mode_signed_i,
        output op1_i,
        output op2_i,
        input  busy_o,
        input  done_o,
        input  zero_o,
        input  sign_o
    );

    modport slave (
        input  start_i,
        input  mode_signed_i,
        input  op1_i,
        input  op2_i,
        output busy_o,
        output done_o,
        output zero_o,
        output sign_o
    );
endinterface

// File: rtl/seq_wide_comparator.sv
// Multi-cycle magnitude comparator for wide operands.
// Operands are latched on START and compared CHUNK bits per cycle, starting
// at the most significant slice and stopping at the first slice that differs.
// Only the top slice uses a signed compare in signed mode: once the top slices
// are equal the operands share a sign, so the remaining slices order the same
// way as plain unsigned magnitudes.
module seq_wide_comparator #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    seq_wide_comparator_if.slave   bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    // Slice table is padded to a power of two so any index value is in range.
    localparam int NSLOT  = 1 << IDX_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_REPORT
    } state_t;

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic             signed_q;
    logic             busy_q;
    logic             done_q;
    logic             zero_q;
    logic             sign_q;

    logic [CHUNK-1:0] slice1 [NSLOT];
    logic [CHUNK-1:0] slice2 [NSLOT];
    logic [CHUNK-1:0] cur1;
    logic [CHUNK-1:0] cur2;
    logic             is_top;
    logic             slice_eq;
    logic             slice_gt;

    // Split the latched operands into CHUNK-wide slices; padding slots read as zero.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slice
            if (gi < NCHUNK) begin : g_real
                assign slice1[gi] = op1_q[gi*CHUNK +: CHUNK];
                assign slice2[gi] = op2_q[gi*CHUNK +: CHUNK];
            end else begin : g_pad
                assign slice1[gi] = '0;
                assign slice2[gi] = '0;
            end
        end
    endgenerate

    assign cur1   = slice1[idx_q];
    assign cur2   = slice2[idx_q];
    assign is_top = (idx_q == IDX_W'(NCHUNK - 1));
    assign idx_d  = idx_q - 1'b1;

    // Compare the currently selected slice pair; signed only for the top slice.
    always_comb begin
        slice_eq = (cur1 == cur2);
        slice_gt = 1'b0;
        if (signed_q && is_top) begin
            slice_gt = ($signed(cur1) > $signed(cur2));
        end else begin
            slice_gt = (cur1 > cur2);
        end
    end

    // Control FSM with registered BUSY/DONE/ZERO/SIGN; reset aborts any operation.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            zero_q   <= 1'b0;
            sign_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op1_q    <= bus.op1_i;
                        op2_q    <= bus.op2_i;
                        signed_q <= bus.mode_signed_i;
                        idx_q    <= IDX_W'(NCHUNK - 1);
                        busy_q   <= 1'b1;
                        state_q  <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (!slice_eq) begin
                        zero_q  <= 1'b0;
                        sign_q  <= slice_gt;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else if (idx_q == '0) begin
                        zero_q  <= 1'b1;
                        sign_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_REPORT;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                S_REPORT: begin
                    // START arriving here is intentionally dropped.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.zero_o = zero_q;
    assign bus.sign_o = sign_q;
endmodule

// File: doc/seq_wide_comparator.md
# seq_wide_comparator

Multi-cycle, parametrised magnitude comparator for wide operands, signed or unsigned. It latches two WIDTH-bit operands on a start pulse and compares them CHUNK bits per cycle, MSB slice first. It stops early at the first differing slice and reports the result on the team's ZERO/SIGN flag convention with a one-cycle DONE pulse. It sits beside the datapath's combinational comparator and serves operand widths too wide to compare in a single cycle at target frequency.

## Interface
- WIDTH, 64: operand width in bits; must be an integer multiple of CHUNK.
- CHUNK, 16: bits compared per cycle; NCHUNK = WIDTH/CHUNK, NCHUNK ≥ 1.
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- START  in  1  request; sampled only in IDLE.
- MODE_SIGNED  in  1  1 = two's-complement compare, 0 = unsigned; latched with START.
- OP1  in  WIDTH  first operand; latched with START.
- OP2  in  WIDTH  second operand; latched with START.
- BUSY  out  1  high while slices are being compared.
- DONE  out  1  one-cycle pulse when ZERO/SIGN carry a new result.
- ZERO  out  1  1 when latched OP1 == OP2.
- SIGN  out  1  1 when latched OP1 > OP2; 0 when OP1 < OP2 or equal.

## Operation
- The FSM has three states: IDLE, COMPARE and REPORT.
- IDLE with START=1:
  - Latch OP1, OP2 and MODE_SIGNED.
  - Set slice index to NCHUNK-1.
  - Go to COMPARE.
- IDLE with START=0: stay in IDLE.
- COMPARE compares slice [index*CHUNK +: CHUNK] of the latched operands each cycle.
  - Top slice (index NCHUNK-1) with MODE_SIGNED=1: signed compare of the slice.
  - All other slices, and every slice when MODE_SIGNED=0: unsigned compare.
  - Slices differ: register ZERO=0 and SIGN=(OP1 slice > OP2 slice), then go to REPORT.
  - Slices equal and index==0: register ZERO=1 and SIGN=0, then go to REPORT.
  - Slices equal and index>0: decrement index and stay in COMPARE.
- REPORT: DONE=1 for this single cycle, then go to IDLE.
- ZERO and SIGN hold their last result until the next REPORT entry. They never show partial or intermediate values.
- BUSY=1 exactly while in COMPARE.
- START is ignored in COMPARE and REPORT. No queuing: a START in REPORT is lost.
- OP1, OP2 and MODE_SIGNED are don't-care outside the START sample cycle.
- CHUNK == WIDTH is legal and degenerates to a single COMPARE cycle.

## Timing
- Reset (RST_N low, asynchronous): state=IDLE, index=0, BUSY=0, DONE=0, ZERO=0, SIGN=0. Latched operands are cleared to 0.
- Reset mid-operation: the operation is aborted immediately. No DONE pulse follows, and outputs take their reset values.
- Define t as the cycle in which START is sampled in IDLE, and k as the number of slices examined (1..NCHUNK).
  - BUSY is high in cycles t+1 .. t+k.
  - DONE is high in cycle t+k+1.
  - ZERO and SIGN are valid from cycle t+k+1 onward.
- Minimum latency is 2 cycles (decided on the MSB slice). Maximum latency is NCHUNK+1 cycles (equal operands, or a difference only in slice 0).
- Earliest next accepted START is cycle t+k+2, giving a throughput of one compare per k+2 cycles.
- There is no combinational path from any input to any output.

## Test plan
All scenarios use WIDTH=64 and CHUNK=16. Cycle numbers are relative to t, the START sample cycle.

1. Equal operands, unsigned: OP1=OP2=64'h0123_4567_89AB_CDEF -> BUSY high for t+1..t+4; DONE at t+5; ZERO=1, SIGN=0.
2. MSB slice decides:
   - OP1=64'h8000_0000_0000_0000, OP2=64'h0000_0000_0000_0001, MODE_SIGNED=0 -> DONE at t+2; ZERO=0, SIGN=1.
   - Same operands with MODE_SIGNED=1 -> DONE at t+2; ZERO=0, SIGN=0.
3. Slice 0 decides, unsigned: OP1=64'hAAAA_BBBB_CCCC_0005, OP2=64'hAAAA_BBBB_CCCC_0007 -> DONE at t+5; ZERO=0, SIGN=0. Swap the operands -> SIGN=1.
4. Both negative, signed: OP1=64'hFFFF_FFFF_FFFF_FFFF (-1), OP2=64'hFFFF_FFFF_FFFF_FFFE (-2), MODE_SIGNED=1 -> DONE at t+5; ZERO=0, SIGN=1.
5. Input isolation during an operation:
   - Start with OP1=64'h10, OP2=64'h20.
   - Pulse START and change OP1/OP2 to 64'hFFFF_FFFF_FFFF_FFFF / 64'h0 during BUSY.
   - Required: only one DONE pulse, at t+5, with ZERO=0, SIGN=0.
   - Required: a START asserted during the REPORT cycle produces no further BUSY.
6. Reset mid-operation:
   - Run scenario 1 and drive RST_N low during t+2.
   - Required: BUSY=0, ZERO=0 and SIGN=0 immediately; no DONE pulse.
   - Release RST_N, then run scenario 2 (unsigned): it completes with DONE 2 cycles after its START and SIGN=1.
